// File: rtl/reg_file_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_file_wr_arbiter
//
// Round-robin arbiter sharing the single write port of a hypervector register
// file among NumReq requesters. The winning request is registered into one
// output stage that drives the register file write port. A per-register
// "written" scoreboard records which registers have been written since the
// last clear or reset.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en_i               arbitration enable (no grants while low)
//   clr_i              synchronous clear of the scoreboard (and counter)
//   req_valid_i        per-requester write request valid
//   req_addr_i         per-requester target register, requester 0 in LSBs
//   req_data_i         per-requester write data, requester 0 in LSBs
//   req_ready_o        per-requester grant, one-hot or zero
//   wr_en_o            register file write enable
//   wr_addr_o          register file write address
//   wr_data_o          register file write data
//   reg_valid_o        bit r set: register r written since last clear/reset
//   contention_cnt_o   (only with REG_FILE_WR_ARB_CONTENTION_EN) saturating
//                      count of enabled cycles with two or more requests
//
// Optional feature macro: REG_FILE_WR_ARB_CONTENTION_EN
// -----------------------------------------------------------------------------
module reg_file_wr_arbiter #(
   parameter int unsigned NumReq       = 3,
   parameter int unsigned DataWidth    = 512,
   parameter int unsigned NumRegs      = 4,
   parameter int unsigned NumRegsWidth = $clog2(NumRegs),
   parameter int unsigned NumReqWidth  = $clog2(NumReq)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             en_i,
   input  logic                             clr_i,
   input  logic [NumReq-1:0]                req_valid_i,
   input  logic [NumReq*NumRegsWidth-1:0]   req_addr_i,
   input  logic [NumReq*DataWidth-1:0]      req_data_i,
   output logic [NumReq-1:0]                req_ready_o,
   output logic                             wr_en_o,
   output logic [NumRegsWidth-1:0]          wr_addr_o,
   output logic [DataWidth-1:0]             wr_data_o,
   output logic [NumRegs-1:0]               reg_valid_o
`ifdef REG_FILE_WR_ARB_CONTENTION_EN
   ,
   output logic [15:0]                      contention_cnt_o
`endif
);

   logic [NumReqWidth-1:0]  ptr_q, ptr_d;
   logic [NumReq-1:0]       grant;
   logic [NumReqWidth-1:0]  grant_idx;
   logic                    found;
   logic [NumRegsWidth-1:0] win_addr;
   logic [DataWidth-1:0]    win_data;

   logic                    wr_en_q;
   logic [NumRegsWidth-1:0] wr_addr_q;
   logic [DataWidth-1:0]    wr_data_q;
   logic [NumRegs-1:0]      reg_valid_q, reg_valid_d;

   // Rotating priority search: p, p+1, ..., NumReq-1, 0, ..., p-1.
   always_comb begin : arb_comb
      int unsigned idx;
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      idx       = 0;
      found     = 1'b0;
      grant_idx = '0;
      grant     = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = (int'(ptr_q) + i) % NumReq;
         if (!found && en_i && req_valid_i[idx]) begin
            found     = 1'b1;
            grant_idx = idx[NumReqWidth-1:0];
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign req_ready_o = grant;

   // Winner's address and data; grant is one-hot so a plain OR-mux suffices.
   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (grant[k]) begin
            win_addr = req_addr_i[k*NumRegsWidth +: NumRegsWidth];
            win_data = req_data_i[k*DataWidth +: DataWidth];
         end
      end
   end

   // The requester after the winner gets first look next time.
   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (grant_idx == NumReqWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Scoreboard: a commit in the same cycle as a clear survives the clear.
   always_comb begin
      reg_valid_d = clr_i ? '0 : reg_valid_q;
      if (wr_en_q) begin
         reg_valid_d[wr_addr_q] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         reg_valid_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         wr_en_q     <= found;
         reg_valid_q <= reg_valid_d;
         // Address/data only load on a transfer and hold otherwise.
         if (found) begin
            wr_addr_q <= win_addr;
            wr_data_q <= win_data;
         end
      end
   end

   assign wr_en_o     = wr_en_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign reg_valid_o = reg_valid_q;

`ifdef REG_FILE_WR_ARB_CONTENTION_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && ($countones(req_valid_i) > 1) && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign contention_cnt_o = cnt_q;
`endif

   // A requester that is waiting for a grant must keep its request up.
   for (genvar k = 0; k < NumReq; k++) begin : g_hold_chk
      assert property (@(posedge clk_i) disable iff (!rst_ni)
         (req_valid_i[k] && !req_ready_o[k]) |=> req_valid_i[k]);
   end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
module tb_reg_file_wr_arbiter;

   localparam int NR  = 3;
   localparam int DW  = 512;
   localparam int NRG = 4;
   localparam int AW  = 2;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             clr;
   logic [NR-1:0]    valid;
   logic [NR*AW-1:0] addr;
   logic [NR*DW-1:0] data;
   logic [NR-1:0]    ready;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [NRG-1:0]   reg_valid;
`ifdef REG_FILE_WR_ARB_CONTENTION_EN
   logic [15:0]      cnt;
`endif

   reg_file_wr_arbiter #(
      .NumReq   (NR),
      .DataWidth(DW),
      .NumRegs  (NRG)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (en),
      .clr_i      (clr),
      .req_valid_i(valid),
      .req_addr_i (addr),
      .req_data_i (data),
      .req_ready_o(ready),
      .wr_en_o    (wr_en),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data),
      .reg_valid_o(reg_valid)
`ifdef REG_FILE_WR_ARB_CONTENTION_EN
      ,
      .contention_cnt_o(cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t            exp_q[$];
   int             order[$];
   int             m_ptr;
   logic [NRG-1:0] m_rv;
   int             m_cnt;
   int             exp_grant;
   int             n_tests;
   int             n_fail;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr[k*AW +: AW] = a;
      data[k*DW +: DW] = d;
   endtask

   // Reference round-robin choice from the bench's own pointer.
   function automatic int model_grant();
      int k;
      if (!en) return -1;
      for (int n = 0; n < NR; n++) begin
         k = (m_ptr + n) % NR;
         if (valid[k]) return k;
      end
      return -1;
   endfunction

   // One clock cycle: check registered outputs and grant at the falling edge,
   // advance the model, then return 1 time unit after the rising edge.
   task automatic cycle();
      wr_t           w;
      logic [NR-1:0] eg;
      logic          commit;
      logic [AW-1:0] caddr;
      @(negedge clk);
      commit = 1'b0;
      caddr  = '0;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         check("wr_en", wr_en, 1'b1);
         check("wr_addr", wr_addr, w.a);
         check("wr_data", wr_data, w.d);
         commit = 1'b1;
         caddr  = w.a;
      end else begin
         check("wr_en_idle", wr_en, 1'b0);
      end
      check("reg_valid", reg_valid, m_rv);
`ifdef REG_FILE_WR_ARB_CONTENTION_EN
      check("contention_cnt", cnt, m_cnt);
`endif
      exp_grant = model_grant();
      eg = '0;
      if (exp_grant >= 0) eg[exp_grant] = 1'b1;
      check("req_ready", ready, eg);
      if (exp_grant >= 0) begin
         w.a = addr[exp_grant*AW +: AW];
         w.d = data[exp_grant*DW +: DW];
         exp_q.push_back(w);
         m_ptr = (exp_grant + 1) % NR;
         order.push_back(exp_grant);
      end
      if (clr) m_cnt = 0;
      else if (en && $countones(valid) >= 2 && m_cnt < 65535) m_cnt++;
      if (clr) m_rv = '0;
      if (commit) m_rv[caddr] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Each requester issues rN transfers, dropping valid only once granted.
   task automatic burst(input int r0, input int r1, input int r2);
      int rem[NR];
      rem = '{r0, r1, r2};
      for (int it = 0; it < 50 && (rem[0] + rem[1] + rem[2]) > 0; it++) begin
         for (int k = 0; k < NR; k++) valid[k] = (rem[k] > 0);
         cycle();
         if (exp_grant >= 0) rem[exp_grant]--;
      end
      valid = '0;
   endtask

   task automatic check_order(input string tag, input int exp[$]);
      int o;
      check({tag, "_len"}, order.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         o = (i < order.size()) ? order[i] : -1;
         check(tag, o, exp[i]);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_wr_en"}, wr_en, 1'b0);
      check({tag, "_wr_addr"}, wr_addr, '0);
      check({tag, "_wr_data"}, wr_data, '0);
      check({tag, "_reg_valid"}, reg_valid, '0);
      check({tag, "_ready"}, ready, '0);
`ifdef REG_FILE_WR_ARB_CONTENTION_EN
      check({tag, "_cnt"}, cnt, 16'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0;
      valid = '0; addr = '0; data = '0;
      m_ptr = 0; m_rv = '0; m_cnt = 0;
      exp_grant = -1; n_tests = 0; n_fail = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;

      // Single request: grant same cycle, write next cycle, scoreboard after
      en = 1'b1;
      set_req(0, 2'd2, 'hA5);
      valid = 3'b001;
      cycle();
      valid = '0;
      cycle();
      check("t1_wr_addr", wr_addr, 2'd2);
      check("t1_reg_valid", reg_valid, 4'b0100);

      // Pointer is 1; one transfer from requester 2 wraps it back to 0
      set_req(2, 2'd3, 'h33);
      burst(0, 0, 1);

      // All three valid: grant order 0,1,2,0,1,2, write every cycle
      set_req(0, 2'd0, 'hA0);
      set_req(1, 2'd1, 'hA1);
      set_req(2, 2'd2, 'hA2);
      order.delete();
      burst(2, 2, 2);
      check_order("t2_order", '{0, 1, 2, 0, 1, 2});
      cycle();

      // Same register from requesters 1 and 2 with pointer at 1
      set_req(0, 2'd0, 'h5);
      burst(1, 0, 0);
      set_req(1, 2'd3, 'h11);
      set_req(2, 2'd3, 'h22);
      order.delete();
      burst(0, 1, 1);
      check_order("t3_order", '{1, 2});
      cycle();
      cycle();
      check("t3_wr_data", wr_data, 'h22);
      check("t3_reg_valid3", reg_valid[3], 1'b1);

      // Enable low: requests wait; on enable requester 1 goes first
      en = 1'b0;
      set_req(1, 2'd1, 'hB1);
      set_req(2, 2'd2, 'hB2);
      valid = 3'b110;
      repeat (3) cycle();
      en = 1'b1;
      order.delete();
      burst(0, 1, 1);
      check_order("t4_order", '{1, 2});
      cycle();

      // Clear in the same cycle as a commit to register 1
      check("t5_reg_valid_full", reg_valid, 4'b1111);
      set_req(0, 2'd1, 'hC1);
      burst(1, 0, 0);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("t5_reg_valid_clr", reg_valid, 4'b0010);

      // Contention: 2 cycles single, 5 cycles all three
      set_req(0, 2'd0, 'hD0);
      set_req(1, 2'd1, 'hD1);
      set_req(2, 2'd2, 'hD2);
      valid = 3'b001;
      repeat (2) cycle();
      valid = 3'b111;
      repeat (5) cycle();
`ifdef REG_FILE_WR_ARB_CONTENTION_EN
      check("t6_cnt", cnt, 16'd5);
`endif
      cycle();

      // Reset mid-burst: everything back to zero, pointer back to 0
      rst_n = 1'b0;
      en    = 1'b0;
      valid = '0;
      #1;
      check_zero_outputs("midreset");
      exp_q.delete();
      m_ptr = 0; m_rv = '0; m_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en    = 1'b1;
      order.delete();
      burst(1, 1, 0);
      check_order("t7_order", '{0, 1});
      cycle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
